rob_nw: RTL and testbench

- Parametrised N-wide reorder buffer; successor to the fixed 2-wide ROB.
- Sits between rename/dispatch (allocation), the CDB (completion) and the PRF/LSQ (in-order retirement).
- Generalised in depth, dispatch width, commit width and CDB port count.
- Adds explicit mispredict/target CDB fields, an exception vector, occupancy outputs, and retire-then-redirect semantics for mispredicted branches and redirecting jumps.

---
 rtl/rob_nw.sv | 217 +++++++++++++++++++++
 tb/tb_rob_nw.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_nw.sv
// Parametrised N-wide reorder buffer: in-order allocation, CDB completion, in-order retirement.
// Optional `ROB_PERF_CNT_EN adds retired-instruction and flush counters.
module rob_nw #(
   parameter int unsigned     DEPTH      = 32,
   parameter int unsigned     DISPATCH_W = 2,
   parameter int unsigned     COMMIT_W   = 2,
   parameter int unsigned     CDB_PORTS  = 2,
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(32'h0000_0100),
   parameter int unsigned     TAG_W      = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DISPATCH_W-1:0]         alloc_req,
   output logic [DISPATCH_W-1:0]         alloc_gnt,
   output logic [DISPATCH_W*TAG_W-1:0]   alloc_tag,
   input  logic [DISPATCH_W*XLEN-1:0]    disp_pc,
   input  logic [DISPATCH_W*5-1:0]       disp_rd,
   input  logic [DISPATCH_W-1:0]         disp_has_rd,
   input  logic [DISPATCH_W-1:0]         disp_is_store,
   input  logic [DISPATCH_W-1:0]         disp_is_jump,
   input  logic [CDB_PORTS-1:0]          cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag,
   input  logic [CDB_PORTS*XLEN-1:0]     cdb_result,
   input  logic [CDB_PORTS-1:0]          cdb_exc,
   input  logic [CDB_PORTS-1:0]          cdb_redirect,
   input  logic [CDB_PORTS*XLEN-1:0]     cdb_target,
   output logic [COMMIT_W-1:0]           commit_valid,
   output logic [COMMIT_W-1:0]           commit_we,
   output logic [COMMIT_W*5-1:0]         commit_rd,
   output logic [COMMIT_W*TAG_W-1:0]     commit_tag,
   output logic [COMMIT_W*XLEN-1:0]      commit_result,
   output logic [COMMIT_W-1:0]           commit_store,
   output logic                          flush,
   output logic [XLEN-1:0]               flush_pc,
   output logic [TAG_W-1:0]              rob_head,
   output logic [TAG_W-1:0]              rob_tail,
   output logic [TAG_W:0]                rob_count,
   output logic                          rob_empty,
   output logic [63:0]                   perf_instret,
   output logic [31:0]                   perf_flushes
);

   localparam int unsigned CNT_W = TAG_W + 1;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic            exc;
      logic            redirect;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic            has_rd;
      logic            is_store;
      logic            is_jump;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [CNT_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [CNT_W-1:0] n_gnt, n_ret, free_c;

   assign free_c    = CNT_W'(DEPTH) - count_q;
   assign rob_head  = head_q[TAG_W-1:0];
   assign rob_tail  = tail_q[TAG_W-1:0];
   assign rob_count = count_q;
   assign rob_empty = (count_q == '0);

   // Prefix-contiguous grants against space known at the start of the cycle
   always_comb begin : alloc_logic
      logic run;
      alloc_gnt = '0;
      alloc_tag = '0;
      n_gnt     = '0;
      run       = !flush;
      for (int i = 0; i < DISPATCH_W; i++) begin
         run          = run && alloc_req[i] && (free_c > CNT_W'(i));
         alloc_gnt[i] = run;
         if (run) begin
            alloc_tag[i*TAG_W +: TAG_W] = tail_q[TAG_W-1:0] + TAG_W'(i);
            n_gnt = n_gnt + CNT_W'(1);
         end
      end
   end

   // In-order retirement; an exception or a retiring redirect stops younger lanes
   always_comb begin : commit_logic
      logic             stop;
      logic [TAG_W-1:0] idx;
      commit_valid  = '0;
      commit_we     = '0;
      commit_rd     = '0;
      commit_tag    = '0;
      commit_result = '0;
      commit_store  = '0;
      flush         = 1'b0;
      flush_pc      = '0;
      n_ret         = '0;
      stop          = 1'b0;
      for (int k = 0; k < COMMIT_W; k++) begin
         idx = head_q[TAG_W-1:0] + TAG_W'(k);
         if (!stop) begin
            if (!(ent_q[idx].valid && ent_q[idx].ready)) begin
               stop = 1'b1;
            end else if (ent_q[idx].exc) begin
               flush    = 1'b1;
               flush_pc = EXC_VECTOR;
               stop     = 1'b1;
            end else begin
               commit_valid[k]                = 1'b1;
               commit_we[k]                   = ent_q[idx].has_rd;
               commit_store[k]                = ent_q[idx].is_store;
               commit_rd[k*5 +: 5]            = ent_q[idx].rd;
               commit_tag[k*TAG_W +: TAG_W]   = idx;
               commit_result[k*XLEN +: XLEN]  = ent_q[idx].is_jump ? ent_q[idx].pc + XLEN'(4)
                                                                   : ent_q[idx].result;
               n_ret = n_ret + CNT_W'(1);
               if (ent_q[idx].redirect) begin
                  flush    = 1'b1;
                  flush_pc = {ent_q[idx].target[XLEN-1:1], 1'b0};
                  stop     = 1'b1;
               end
            end
         end
      end
   end

   // Completion, then retirement/flush, then allocation of new entries
   always_comb begin : next_state
      logic [TAG_W-1:0] idx;
      entry_t           ne;
      ent_d   = ent_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      idx     = '0;
      ne      = '0;
      for (int p = 0; p < CDB_PORTS; p++) begin
         idx = cdb_tag[p*TAG_W +: TAG_W];
         if (cdb_valid[p] && ent_q[idx].valid) begin
            ent_d[idx].ready    = 1'b1;
            ent_d[idx].result   = cdb_result[p*XLEN +: XLEN];
            ent_d[idx].exc      = cdb_exc[p];
            ent_d[idx].redirect = cdb_redirect[p];
            ent_d[idx].target   = cdb_target[p*XLEN +: XLEN];
         end
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int k = 0; k < COMMIT_W; k++) begin
            idx = head_q[TAG_W-1:0] + TAG_W'(k);
            if (commit_valid[k]) ent_d[idx].valid = 1'b0;
         end
         for (int i = 0; i < DISPATCH_W; i++) begin
            idx         = tail_q[TAG_W-1:0] + TAG_W'(i);
            ne          = '0;
            ne.valid    = 1'b1;
            ne.pc       = disp_pc[i*XLEN +: XLEN];
            ne.rd       = disp_rd[i*5 +: 5];
            ne.has_rd   = disp_has_rd[i];
            ne.is_store = disp_is_store[i];
            ne.is_jump  = disp_is_jump[i];
            if (alloc_gnt[i]) ent_d[idx] = ne;
         end
         head_d  = head_q + n_ret;
         tail_d  = tail_q + n_gnt;
         count_d = count_q + n_gnt - n_ret;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ent_q   <= ent_d;
      end
   end

`ifdef ROB_PERF_CNT_EN
   logic [63:0] instret_q, instret_d;
   logic [31:0] flushes_q, flushes_d;

   always_comb begin
      instret_d = instret_q + 64'(n_ret);
      flushes_d = flushes_q + 32'(flush);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instret_q <= '0;
         flushes_q <= '0;
      end else begin
         instret_q <= instret_d;
         flushes_q <= flushes_d;
      end
   end

   assign perf_instret = instret_q;
   assign perf_flushes = flushes_q;
`else
   assign perf_instret = '0;
   assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_rob_nw.sv
// Self-checking bench for rob_nw: directed scenarios plus randomized traffic against a queue model.
module tb_rob_nw;
   localparam int DEPTH = 32;
   localparam int DW    = 2;
   localparam int CW    = 2;
   localparam int NP    = 2;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;
   localparam logic [31:0] EXC_VEC = 32'h0000_0100;
`ifdef ROB_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic [DW-1:0]          alloc_req, alloc_gnt, disp_has_rd, disp_is_store, disp_is_jump;
   logic [DW*TAG_W-1:0]    alloc_tag;
   logic [DW*XLEN-1:0]     disp_pc;
   logic [DW*5-1:0]        disp_rd;
   logic [NP-1:0]          cdb_valid, cdb_exc, cdb_redirect;
   logic [NP*TAG_W-1:0]    cdb_tag;
   logic [NP*XLEN-1:0]     cdb_result, cdb_target;
   logic [CW-1:0]          commit_valid, commit_we, commit_store;
   logic [CW*5-1:0]        commit_rd;
   logic [CW*TAG_W-1:0]    commit_tag;
   logic [CW*XLEN-1:0]     commit_result;
   logic                   flush, rob_empty;
   logic [XLEN-1:0]        flush_pc;
   logic [TAG_W-1:0]       rob_head, rob_tail;
   logic [TAG_W:0]         rob_count;
   logic [63:0]            perf_instret;
   logic [31:0]            perf_flushes;

   int errors = 0;
   int checks = 0;

   rob_nw #(.DEPTH(DEPTH), .DISPATCH_W(DW), .COMMIT_W(CW), .CDB_PORTS(NP), .XLEN(XLEN),
            .EXC_VECTOR(EXC_VEC)) dut (
      .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .disp_pc(disp_pc), .disp_rd(disp_rd), .disp_has_rd(disp_has_rd),
      .disp_is_store(disp_is_store), .disp_is_jump(disp_is_jump),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result), .cdb_exc(cdb_exc),
      .cdb_redirect(cdb_redirect), .cdb_target(cdb_target),
      .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
      .commit_tag(commit_tag), .commit_result(commit_result), .commit_store(commit_store),
      .flush(flush), .flush_pc(flush_pc), .rob_head(rob_head), .rob_tail(rob_tail),
      .rob_count(rob_count), .rob_empty(rob_empty),
      .perf_instret(perf_instret), .perf_flushes(perf_flushes));

   always #5 clk = ~clk;

   // Reference model: program-order queue of in-flight instructions; q[0] holds tag m_head
   typedef struct {
      bit          ready, exc, redir, has_rd, st, jmp;
      logic [31:0] target, result, pc;
      logic [4:0]  rd;
   } ment_t;

   ment_t  q[$];
   int     m_head;
   longint m_instret;
   int     m_flushes;

   function automatic void model_eval(output logic [DW-1:0] g, output logic [CW-1:0] cv,
                                      output bit fl, output logic [31:0] fpc, output int nret);
      bit run;
      g = '0; cv = '0; fl = 1'b0; fpc = '0; nret = 0;
      for (int k = 0; k < CW; k++) begin
         if (k >= q.size()) break;
         if (!q[k].ready) break;
         if (q[k].exc) begin fl = 1'b1; fpc = EXC_VEC; break; end
         cv[k] = 1'b1;
         nret++;
         if (q[k].redir) begin fl = 1'b1; fpc = {q[k].target[31:1], 1'b0}; break; end
      end
      run = !fl;
      for (int i = 0; i < DW; i++) begin
         run  = run && alloc_req[i] && ((DEPTH - q.size()) > i);
         g[i] = run;
      end
   endfunction

   // Advance one clock: update the model with the inputs present at the edge
   task automatic tick();
      logic [DW-1:0] g;
      logic [CW-1:0] cv;
      bit            fl;
      logic [31:0]   fpc;
      int            nret, idx;
      ment_t         e;
      @(posedge clk);
      model_eval(g, cv, fl, fpc, nret);
      for (int p = 0; p < NP; p++) begin
         if (cdb_valid[p]) begin
            idx = (int'(cdb_tag[p*TAG_W +: TAG_W]) - m_head + DEPTH) % DEPTH;
            if (idx < q.size()) begin
               q[idx].ready  = 1'b1;
               q[idx].result = cdb_result[p*XLEN +: XLEN];
               q[idx].exc    = cdb_exc[p];
               q[idx].redir  = cdb_redirect[p];
               q[idx].target = cdb_target[p*XLEN +: XLEN];
            end
         end
      end
      m_instret += longint'(nret);
      if (fl) begin
         m_flushes++;
         q.delete();
         m_head = 0;
      end else begin
         for (int k = 0; k < nret; k++) void'(q.pop_front());
         m_head = (m_head + nret) % DEPTH;
         for (int i = 0; i < DW; i++) begin
            if (g[i]) begin
               e = '{ready: 1'b0, exc: 1'b0, redir: 1'b0, has_rd: disp_has_rd[i],
                     st: disp_is_store[i], jmp: disp_is_jump[i], target: '0, result: '0,
                     pc: disp_pc[i*XLEN +: XLEN], rd: disp_rd[i*5 +: 5]};
               q.push_back(e);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic set_idle();
      alloc_req = '0; disp_pc = '0; disp_rd = '0; disp_has_rd = '0; disp_is_store = '0;
      disp_is_jump = '0; cdb_valid = '0; cdb_tag = '0; cdb_result = '0; cdb_exc = '0;
      cdb_redirect = '0; cdb_target = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b0;
      q.delete(); m_head = 0; m_instret = 0; m_flushes = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b0;
      q.delete(); m_head = 0; m_instret = 0; m_flushes = 0;
      #3;
      checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", rob_empty); end
      checks++; if (rob_tail !== '0 || rob_head !== '0) begin errors++; $display("FAIL rst_ptrs head=%0d tail=%0d exp=0", rob_head, rob_tail); end
      checks++; if (alloc_tag !== '0 || flush_pc !== '0) begin errors++; $display("FAIL rst_zero tag=%h fpc=%h exp=0", alloc_tag, flush_pc); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) tick();
      #1;
      checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL idle_empty got=%b exp=1", rob_empty); end
      checks++; if (rob_count !== '0) begin errors++; $display("FAIL idle_count got=%0d exp=0", rob_count); end
      checks++; if (commit_valid !== '0 || flush !== 1'b0) begin errors++; $display("FAIL idle_commit cv=%b flush=%b exp=0", commit_valid, flush); end
      checks++; if (perf_instret !== '0 || perf_flushes !== '0) begin errors++; $display("FAIL idle_perf %0d %0d exp=0", perf_instret, perf_flushes); end
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int c = 0; c < 16; c++) begin
         alloc_req = 2'b11;
         #1;
         checks++; if (alloc_gnt !== 2'b11) begin errors++; $display("FAIL fill_gnt c=%0d got=%b exp=11", c, alloc_gnt); end
         checks++; if (alloc_tag !== {5'(2*c+1), 5'(2*c)}) begin errors++; $display("FAIL fill_tag c=%0d got=%h", c, alloc_tag); end
         tick();
      end
      #1;
      checks++; if (rob_count !== 6'd32) begin errors++; $display("FAIL full_count got=%0d exp=32", rob_count); end
      checks++; if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL full_gnt got=%b exp=00", alloc_gnt); end
      cdb_valid = 2'b11; cdb_tag = {5'd1, 5'd0}; cdb_result = {32'hBBBB_0001, 32'hAAAA_0000};
      tick();
      cdb_valid = '0;
      #1;
      checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL full_commit got=%b exp=11", commit_valid); end
      checks++; if (commit_tag !== {5'd1, 5'd0}) begin errors++; $display("FAIL full_ctag got=%h exp=020", commit_tag); end
      checks++; if (commit_result !== {32'hBBBB_0001, 32'hAAAA_0000}) begin errors++; $display("FAIL full_cres got=%h", commit_result); end
      checks++; if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL full_nofree got=%b exp=00", alloc_gnt); end
      tick();
      #1;
      checks++; if (rob_count !== 6'd30) begin errors++; $display("FAIL wrap_count got=%0d exp=30", rob_count); end
      checks++; if (alloc_gnt !== 2'b11) begin errors++; $display("FAIL wrap_gnt got=%b exp=11", alloc_gnt); end
      checks++; if (alloc_tag !== {5'd1, 5'd0}) begin errors++; $display("FAIL wrap_tag got=%h exp=020", alloc_tag); end
      tick();
      alloc_req = '0;
   endtask

   task automatic test_partial_grant();
      do_reset();
      alloc_req = 2'b10;
      #1;
      checks++; if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL prefix_gnt got=%b exp=00", alloc_gnt); end
      tick();
      alloc_req = 2'b11;
      repeat (15) tick();
      alloc_req = 2'b01;
      tick();
      alloc_req = 2'b11;
      #1;
      checks++; if (rob_count !== 6'd31) begin errors++; $display("FAIL part_count got=%0d exp=31", rob_count); end
      checks++; if (alloc_gnt !== 2'b01) begin errors++; $display("FAIL part_gnt got=%b exp=01", alloc_gnt); end
      checks++; if (alloc_tag[4:0] !== 5'd31) begin errors++; $display("FAIL part_tag got=%0d exp=31", alloc_tag[4:0]); end
      tick();
      alloc_req = '0;
      #1;
      checks++; if (rob_count !== 6'd32 || rob_tail !== 5'd0) begin errors++; $display("FAIL part_full count=%0d tail=%0d exp=32/0", rob_count, rob_tail); end
   endtask

   task automatic test_out_of_order();
      do_reset();
      alloc_req = 2'b11; disp_is_store = 2'b10; disp_has_rd = 2'b10; disp_rd = {5'd5, 5'd0};
      tick();
      set_idle();
      alloc_req = 2'b11;
      tick();
      set_idle();
      for (int s = 0; s < 4; s++) begin
         cdb_valid = 2'b01; cdb_tag = {5'd0, 5'(3 - s)}; cdb_result = {32'h0, 32'(32'h100 + 3 - s)};
         #1;
         checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait s=%0d got=%b exp=00", s, commit_valid); end
         tick();
      end
      set_idle();
      #1;
      checks++; if (commit_valid !== 2'b11 || commit_tag !== {5'd1, 5'd0}) begin errors++; $display("FAIL ooo_c01 cv=%b tag=%h", commit_valid, commit_tag); end
      checks++; if (commit_store !== 2'b10 || commit_we !== 2'b10) begin errors++; $display("FAIL ooo_store st=%b we=%b exp=10/10", commit_store, commit_we); end
      checks++; if (commit_rd[9:5] !== 5'd5) begin errors++; $display("FAIL ooo_rd got=%0d exp=5", commit_rd[9:5]); end
      tick();
      #1;
      checks++; if (commit_valid !== 2'b11 || commit_tag !== {5'd3, 5'd2}) begin errors++; $display("FAIL ooo_c23 cv=%b tag=%h", commit_valid, commit_tag); end
      checks++; if (commit_result !== {32'h103, 32'h102}) begin errors++; $display("FAIL ooo_res got=%h", commit_result); end
      tick();
      #1;
      checks++; if (rob_empty !== 1'b1 || commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_drain empty=%b cv=%b", rob_empty, commit_valid); end
   endtask

   task automatic test_mispredict();
      do_reset();
      alloc_req = 2'b11; disp_pc = {32'h0000_1004, 32'h0000_1000};
      tick();
      set_idle();
      cdb_valid = 2'b11; cdb_tag = {5'd1, 5'd0}; cdb_redirect = 2'b01;
      cdb_target = {32'h0, 32'h0000_2001}; cdb_result = {32'h55, 32'h44};
      tick();
      set_idle();
      alloc_req = 2'b11;
      #1;
      checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL mp_cv got=%b exp=01", commit_valid); end
      checks++; if (flush !== 1'b1 || flush_pc !== 32'h0000_2000) begin errors++; $display("FAIL mp_flush f=%b pc=%h exp=1/00002000", flush, flush_pc); end
      checks++; if (alloc_gnt !== 2'b00) begin errors++; $display("FAIL mp_gnt got=%b exp=00", alloc_gnt); end
      tick();
      alloc_req = '0;
      #1;
      checks++; if (rob_count !== '0 || rob_tail !== '0) begin errors++; $display("FAIL mp_after count=%0d tail=%0d exp=0", rob_count, rob_tail); end
      checks++; if (commit_valid !== 2'b00 || flush !== 1'b0) begin errors++; $display("FAIL mp_noretire cv=%b f=%b", commit_valid, flush); end
   endtask

   task automatic test_exception();
      do_reset();
      alloc_req = 2'b11; disp_has_rd = 2'b01; disp_rd = {5'd0, 5'd7};
      tick();
      set_idle();
      cdb_valid = 2'b11; cdb_tag = {5'd1, 5'd0}; cdb_exc = 2'b10; cdb_result = {32'h0, 32'h0000_DEAD};
      tick();
      set_idle();
      #1;
      checks++; if (commit_valid !== 2'b01 || commit_we !== 2'b01) begin errors++; $display("FAIL exc_cv cv=%b we=%b exp=01/01", commit_valid, commit_we); end
      checks++; if (commit_rd[4:0] !== 5'd7 || commit_result[31:0] !== 32'h0000_DEAD) begin errors++; $display("FAIL exc_data rd=%0d res=%h", commit_rd[4:0], commit_result[31:0]); end
      checks++; if (flush !== 1'b1 || flush_pc !== EXC_VEC) begin errors++; $display("FAIL exc_flush f=%b pc=%h exp=1/%h", flush, flush_pc, EXC_VEC); end
      tick();
      #1;
      checks++; if (rob_count !== '0) begin errors++; $display("FAIL exc_count got=%0d exp=0", rob_count); end
      checks++; if (perf_instret !== (PERF ? 64'd1 : 64'd0)) begin errors++; $display("FAIL exc_instret got=%0d", perf_instret); end
      checks++; if (perf_flushes !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL exc_flushes got=%0d", perf_flushes); end
   endtask

   task automatic test_random();
      logic [DW-1:0] g;
      logic [CW-1:0] cv, ewe, est;
      bit            fl;
      logic [31:0]   fpc, eres;
      int            nret, pct;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         pct = ((c / 250) % 2 == 1) ? 15 : 65;
         alloc_req = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         for (int i = 0; i < DW; i++) begin
            disp_pc[i*XLEN +: XLEN] = $urandom & 32'hFFFF_FFFC;
            disp_rd[i*5 +: 5]       = 5'($urandom);
            disp_has_rd[i]          = 1'($urandom);
            disp_is_store[i]        = ($urandom_range(0, 3) == 0);
            disp_is_jump[i]         = ($urandom_range(0, 7) == 0);
         end
         for (int p = 0; p < NP; p++) begin
            cdb_valid[p] = ($urandom_range(0, 99) < pct);
            if (q.size() > 0 && $urandom_range(0, 7) != 0)
               cdb_tag[p*TAG_W +: TAG_W] = 5'((m_head + $urandom_range(0, q.size() - 1)) % DEPTH);
            else
               cdb_tag[p*TAG_W +: TAG_W] = 5'($urandom);
            cdb_result[p*XLEN +: XLEN] = $urandom;
            cdb_target[p*XLEN +: XLEN] = $urandom;
            cdb_exc[p]      = ($urandom_range(0, 39) == 0);
            cdb_redirect[p] = ($urandom_range(0, 15) == 0);
         end
         #1;
         model_eval(g, cv, fl, fpc, nret);
         ewe = '0; est = '0;
         for (int k = 0; k < CW; k++) begin
            if (cv[k]) begin ewe[k] = q[k].has_rd; est[k] = q[k].st; end
         end
         checks++; if (alloc_gnt !== g) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, alloc_gnt, g); end
         checks++; if (commit_valid !== cv) begin errors++; $display("FAIL rnd_cv c=%0d got=%b exp=%b", c, commit_valid, cv); end
         checks++; if (flush !== fl) begin errors++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush, fl); end
         checks++; if (commit_we !== ewe || commit_store !== est) begin errors++; $display("FAIL rnd_we_st c=%0d we=%b/%b st=%b/%b", c, commit_we, ewe, commit_store, est); end
         checks++; if (rob_count !== 6'(q.size()) || rob_empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, rob_count, q.size()); end
         checks++; if (rob_head !== 5'(m_head) || rob_tail !== 5'((m_head + q.size()) % DEPTH)) begin errors++; $display("FAIL rnd_ptr c=%0d head=%0d tail=%0d", c, rob_head, rob_tail); end
         if (fl) begin
            checks++; if (flush_pc !== fpc) begin errors++; $display("FAIL rnd_fpc c=%0d got=%h exp=%h", c, flush_pc, fpc); end
         end
         for (int i = 0; i < DW; i++) begin
            if (g[i]) begin
               checks++; if (alloc_tag[i*TAG_W +: TAG_W] !== 5'((m_head + q.size() + i) % DEPTH)) begin errors++; $display("FAIL rnd_atag c=%0d lane=%0d got=%0d", c, i, alloc_tag[i*TAG_W +: TAG_W]); end
            end
         end
         for (int k = 0; k < CW; k++) begin
            if (cv[k]) begin
               eres = q[k].jmp ? q[k].pc + 32'd4 : q[k].result;
               checks++; if (commit_tag[k*TAG_W +: TAG_W] !== 5'((m_head + k) % DEPTH)) begin errors++; $display("FAIL rnd_ctag c=%0d lane=%0d got=%0d", c, k, commit_tag[k*TAG_W +: TAG_W]); end
               checks++; if (commit_result[k*XLEN +: XLEN] !== eres || commit_rd[k*5 +: 5] !== q[k].rd) begin errors++; $display("FAIL rnd_cdata c=%0d lane=%0d res=%h exp=%h", c, k, commit_result[k*XLEN +: XLEN], eres); end
            end
         end
         checks++; if (perf_instret !== (PERF ? 64'(m_instret) : 64'd0) || perf_flushes !== (PERF ? 32'(m_flushes) : 32'd0)) begin errors++; $display("FAIL rnd_perf c=%0d ret=%0d fl=%0d", c, perf_instret, perf_flushes); end
         tick();
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      rst = 1'b0;
      test_reset();
      test_fill_full();
      test_partial_grant();
      test_out_of_order();
      test_mispredict();
      test_exception();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
